// File: rtl/zxw_alu_blogic.sv
// ZXW ALU bitwise logic unit: XOR/OR/AND/NOT-A selected by {fs2,fs1}, one-clock registered result.
// Optional registered zero/ones result flags are built when BLOGIC_FLAGS_EN is defined.
module zxw_alu_blogic #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             fs2,
  input  logic             fs1,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] fun,
  output logic             fun_valid
`ifdef BLOGIC_FLAGS_EN
  ,
  output logic             zero_flag,
  output logic             ones_flag
`endif
);

  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] fun_q, fun_d;
  logic             valid_q;

  // Each result bit depends only on bit gi of A and B; no cross-bit path exists.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      always_comb begin
        unique case ({fs2, fs1})
          2'b00:   nxt[gi] = A[gi] ^ B[gi];
          2'b01:   nxt[gi] = A[gi] | B[gi];
          2'b10:   nxt[gi] = A[gi] & B[gi];
          default: nxt[gi] = ~A[gi];
        endcase
      end
    end
  endgenerate

  assign fun_d = en ? nxt : fun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fun_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      fun_q   <= fun_d;
      valid_q <= en;
    end
  end

  assign fun       = fun_q;
  assign fun_valid = valid_q;

`ifdef BLOGIC_FLAGS_EN
  logic zero_q, zero_d;
  logic ones_q, ones_d;

  assign zero_d = en ? (nxt == '0) : zero_q;
  assign ones_d = en ? (&nxt)      : ones_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      ones_q <= 1'b0;
    end else begin
      zero_q <= zero_d;
      ones_q <= ones_d;
    end
  end

  assign zero_flag = zero_q;
  assign ones_flag = ones_q;
`endif

endmodule

// File: tb/tb_zxw_alu_blogic.sv
// Scoreboard bench for zxw_alu_blogic (WIDTH=4); covers the flag outputs when BLOGIC_FLAGS_EN is defined.
module tb_zxw_alu_blogic;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         fs2, fs1;
  logic [W-1:0] A, B;
  logic [W-1:0] fun;
  logic         fun_valid;
`ifdef BLOGIC_FLAGS_EN
  logic         zero_flag, ones_flag;
`endif

  zxw_alu_blogic #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .fs2       (fs2),
    .fs1       (fs1),
    .A         (A),
    .B         (B),
    .fun       (fun),
    .fun_valid (fun_valid)
`ifdef BLOGIC_FLAGS_EN
    ,
    .zero_flag (zero_flag),
    .ones_flag (ones_flag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] f;
    logic         v;
    logic         z;
    logic         o;
  } exp_t;

  exp_t         sb_q[$];
  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] m_fun = '0;
  logic         m_z   = 1'b0;
  logic         m_o   = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [1:0] sel, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (sel)
      2'b00:   return a ^ b;
      2'b01:   return a | b;
      2'b10:   return a & b;
      default: return ~a;
    endcase
  endfunction

  // Called at posedge+1: drive, predict, clock once, then compare against the popped entry.
  task automatic do_op(input string tag, input logic e, input logic [1:0] sel,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t x;
    logic [W-1:0] r;
    en = e; fs2 = sel[1]; fs1 = sel[0]; A = a; B = b;
    if (e) begin
      r     = ref_op(sel, a, b);
      m_fun = r;
      m_z   = (r == '0);
      m_o   = (r == {W{1'b1}});
    end
    x.f = m_fun; x.v = e; x.z = m_z; x.o = m_o;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    $display("op %-8s en=%0b sel=%0b%0b A=%h B=%h -> fun=%h valid=%0b", tag, e, sel[1], sel[0],
             a, b, fun, fun_valid);
    chk({tag, ".fun"}, 64'(fun), 64'(x.f));
    chk({tag, ".vld"}, 64'(fun_valid), 64'(x.v));
`ifdef BLOGIC_FLAGS_EN
    chk({tag, ".zf"}, 64'(zero_flag), 64'(x.z));
    chk({tag, ".of"}, 64'(ones_flag), 64'(x.o));
`endif
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; fs2 = 1'b0; fs1 = 1'b0; A = 4'hF; B = 4'hF;
    #1;
    chk("rst0.fun", 64'(fun), 64'h0);
    chk("rst0.vld", 64'(fun_valid), 64'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      $display("reset cycle %0d fun=%h valid=%0b", i, fun, fun_valid);
      chk("rst.fun", 64'(fun), 64'h0);
      chk("rst.vld", 64'(fun_valid), 64'h0);
    end
    rst_n = 1'b1;

    do_op("first",  1'b1, 2'b00, 4'hF, 4'hF);
    do_op("xor0",   1'b1, 2'b00, 4'h0, 4'h0);
    do_op("xorAC",  1'b1, 2'b00, 4'hA, 4'h6);
    do_op("or0F",   1'b1, 2'b01, 4'h0, 4'hF);
    do_op("and0F",  1'b1, 2'b10, 4'h0, 4'hF);
    do_op("andCA",  1'b1, 2'b10, 4'hC, 4'hA);
    do_op("not01",  1'b1, 2'b11, 4'h0, 4'h1);
    do_op("not5F",  1'b1, 2'b11, 4'h5, 4'hF);

    do_op("capF",   1'b1, 2'b01, 4'h0, 4'hF);
    do_op("hold1",  1'b0, 2'b10, 4'h0, 4'h0);
    do_op("hold2",  1'b0, 2'b00, 4'hF, 4'hF);
    do_op("hold3",  1'b0, 2'b11, 4'hF, 4'h3);

    // Asynchronous reset pulse between clock edges.
    #2 rst_n = 1'b0;
    #1;
    $display("async reset fun=%h valid=%0b", fun, fun_valid);
    chk("arst.fun", 64'(fun), 64'h0);
    chk("arst.vld", 64'(fun_valid), 64'h0);
`ifdef BLOGIC_FLAGS_EN
    chk("arst.zf", 64'(zero_flag), 64'h0);
    chk("arst.of", 64'(ones_flag), 64'h0);
`endif
    m_fun = '0; m_z = 1'b0; m_o = 1'b0;
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_op("hold0",  1'b0, 2'b01, 4'hF, 4'hF);
    do_op("post",   1'b1, 2'b01, 4'h3, 4'h4);

    for (int i = 0; i < 24; i++)
      do_op("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL timeout: got no finish, expected finish before 100us");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
